sys_readback: RTL and testbench
===============================

Name: sys_readback

Overview:
- Read-back responder for the host register bus. The host issues a read strobe and an 8-bit address.
- On each accepted read, the block snapshots the addressed system register value and returns it as a 5-byte frame over a byte-stream valid/ready interface toward the USB/UART transmitter.
- Frame format: address echo byte, then the data bytes, LSB first.
- It sits beside the write-side register bank and shares the same i_addr decode space.

Parameters:
- NUM_REGS, 8: number of readable 32-bit registers; BASE_ADDR+NUM_REGS must be ≤ 255.
- BASE_ADDR, 0: bus address of register index 0.
- DATA_BYTES, 4: data bytes per frame; fixed at 4 for 32-bit registers.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  read request strobe, sampled on the rising edge.
- i_addr  in  8  read address, valid with i_read.
- i_reg_data  in  32*NUM_REGS  flattened register values; index k occupies bits [32k+31:32k].
- o_busy  out  1  frame in progress; requests are ignored while high.
- o_tx_data  out  8  frame byte.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  transmitter accepts the byte.
- o_done  out  1  one-cycle pulse after the final byte is transferred.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - o_busy, o_tx_valid and o_done are 0.
  - o_tx_data is 0.
  - Byte counter and snapshot are 0.
  - Reset mid-frame aborts the frame immediately; no partial resume.
- States: IDLE, SEND.
- IDLE:
  - A request is accepted when i_read=1 in IDLE.
  - On acceptance, on the same edge: snapshot word, load header, byte count=0, go to SEND.
  - Snapshot word: register (i_addr-BASE_ADDR) if BASE_ADDR ≤ i_addr < BASE_ADDR+NUM_REGS; otherwise 32'h0000_0000.
  - Header: i_addr if in range; otherwise 8'hFF (ERR_HDR).
- SEND:
  - o_tx_valid=1 and o_busy=1.
  - o_tx_data = byte[count], where byte0=header, byte1=data[7:0], … byte4=data[31:24].
- Latency: i_read accepted at edge N → first byte is on o_tx_valid/o_tx_data after edge N.
- Handshake:
  - A byte transfers on an edge where o_tx_valid && i_tx_ready; count then increments.
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data holds stable.
  - o_tx_valid never drops until the byte transfers.
- Frame completion:
  - Transfer of byte4 → state=IDLE, o_tx_valid=0, o_busy=0, o_done=1 for exactly one cycle.
  - With i_tx_ready held at 1, the frame takes 5 cycles and there are no gaps between bytes.
- Back-to-back requests:
  - i_read while busy (including the cycle byte4 transfers) is dropped, not queued.
  - The earliest next acceptance is the cycle after o_done asserts, since the block is back in IDLE then.
- Snapshot isolation: changes on i_reg_data after acceptance do not alter the frame in flight.
- Address arithmetic:
  - The index is computed as 8-bit unsigned i_addr-BASE_ADDR.
  - The range check is performed before subtraction, so there is no wrap to a valid index.
- o_tx_data is 0 whenever o_tx_valid=0.

Decomposition:
- Shared package sys_pkg holds:
  - State enum (IDLE, SEND).
  - ERR_HDR=8'hFF.
  - FRAME_BYTES=DATA_BYTES+1.
  - Register width constant 32.
- One natural sub-module: sys_byte_serializer.
  - Loads a 40-bit {data,header} frame and emits it byte-wise over valid/ready.
  - Provides done and busy signals.
  - The top level owns address decode, the snapshot mux, and request accept.

Test Plan:
- Basic read: NUM_REGS=8, BASE_ADDR=0, reg3=32'hA1B2C3D4, i_read with i_addr=3, i_tx_ready=1 → bytes 03,D4,C3,B2,A1 on 5 consecutive cycles, first one cycle after the request edge; o_done pulses once; o_busy low afterwards.
- Backpressure: same read, i_tx_ready toggling 1,0,0,1,… → each byte held stable while not ready; sequence unchanged; no byte duplicated or skipped.
- Out of range: i_addr=8, then i_addr=200 → frame FF,00,00,00,00 for each.
- Busy drop and snapshot: i_read addr=1 accepted, second i_read addr=2 during the frame, reg1 changed mid-frame → only one frame, carrying the original reg1 value; a new read accepted the cycle after o_done succeeds.
- Reset mid-frame: assert i_rst_n=0 after byte 2 → o_tx_valid, o_busy and o_tx_data go to 0 asynchronously; after release, a new read produces a complete fresh 5-byte frame.
- BASE_ADDR=16: i_addr=15 → error frame FF,00,00,00,00; i_addr=16 → frame with header 10 carrying reg0; i_addr=23 → frame with header 17 carrying reg7.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared constants and types for the register read-back responder.
// Frame layout is a header byte followed by the register word, LSB first.
package sys_pkg;

    localparam int unsigned REG_W       = 32;
    localparam int unsigned REG_BYTES   = REG_W / 8;
    localparam int unsigned FRAME_BYTES = REG_BYTES + 1;
    localparam logic [7:0]  ERR_HDR     = 8'hFF;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

endpackage

// File: rtl/sys_byte_serializer.sv
// Loads a {data, header} frame and emits it byte-wise, LSB first, over valid/ready.
// All outputs are registered; done pulses for one cycle after the final byte transfers.
module sys_byte_serializer
    import sys_pkg::*;
#(
    parameter int unsigned NBYTES = FRAME_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [8*NBYTES-1:0]   frame,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned    CW   = $clog2(NBYTES);
    localparam logic [CW-1:0]  LAST = CW'(NBYTES - 1);

    state_e              state;
    logic [8*NBYTES-1:0] shreg;
    logic [CW-1:0]       count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            shreg    <= '0;
            count    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (load) begin
                        shreg    <= frame;
                        count    <= '0;
                        tx_data  <= frame[7:0];
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= StSend;
                    end
                end
                StSend: begin
                    if (tx_valid && tx_ready) begin
                        if (count == LAST) begin
                            state    <= StIdle;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            tx_data  <= '0;
                            done     <= 1'b1;
                        end else begin
                            // Shift so the next byte always sits in bits [15:8].
                            count   <= count + 1'b1;
                            tx_data <= shreg[15:8];
                            shreg   <= shreg >> 8;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/sys_readback.sv
// Host register read-back responder: decodes a read address, snapshots the addressed
// register and returns it as a 5-byte frame through the byte serializer.
module sys_readback
    import sys_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_read,
    input  logic [7:0]                i_addr,
    input  logic [REG_W*NUM_REGS-1:0] i_reg_data,
    output logic                      o_busy,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_done
);

    localparam int unsigned FB     = DATA_BYTES + 1;
    localparam logic [8:0]  LO_ADR = 9'(BASE_ADDR);
    localparam logic [8:0]  NREG   = 9'(NUM_REGS);

    logic [8:0]       offset;
    logic             in_range;
    logic [7:0]       hdr;
    logic [REG_W-1:0] snap;
    logic [8*FB-1:0]  frame;
    logic             accept;
    logic             busy;

    // A 9-bit difference exposes the borrow, so addresses below the base never wrap
    // into a valid index.
    always_comb begin
        offset   = {1'b0, i_addr} - LO_ADR;
        in_range = !offset[8] && (offset < NREG);
        hdr      = ERR_HDR;
        snap     = '0;
        if (in_range) begin
            hdr = i_addr;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (offset[7:0] == 8'(k)) begin
                    snap = i_reg_data[REG_W*k +: REG_W];
                end
            end
        end
    end

    assign frame  = {snap, hdr};
    assign accept = i_read && !busy;
    assign o_busy = busy;

    sys_byte_serializer #(
        .NBYTES (FB)
    ) u_ser (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (accept),
        .frame    (frame),
        .tx_ready (i_tx_ready),
        .tx_data  (o_tx_data),
        .tx_valid (o_tx_valid),
        .busy     (busy),
        .done     (o_done)
    );

endmodule

// File: tb/tb_sys_readback.sv
// Directed bench for sys_readback: two instances (base 0 and base 16) share stimulus
// and run frames in lockstep; each step checks against hand-computed frames.
module tb_sys_readback;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd;
    logic [7:0]   addr;
    logic [255:0] regs;
    logic         ready;

    logic         a_busy, a_valid, a_done;
    logic [7:0]   a_data;
    logic         b_busy, b_valid, b_done;
    logic [7:0]   b_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sys_readback #(
        .NUM_REGS   (8),
        .BASE_ADDR  (0),
        .DATA_BYTES (4)
    ) dut_a (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_read     (rd),
        .i_addr     (addr),
        .i_reg_data (regs),
        .o_busy     (a_busy),
        .o_tx_data  (a_data),
        .o_tx_valid (a_valid),
        .i_tx_ready (ready),
        .o_done     (a_done)
    );

    sys_readback #(
        .NUM_REGS   (8),
        .BASE_ADDR  (16),
        .DATA_BYTES (4)
    ) dut_b (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_read     (rd),
        .i_addr     (addr),
        .i_reg_data (regs),
        .o_busy     (b_busy),
        .o_tx_data  (b_data),
        .o_tx_valid (b_valid),
        .i_tx_ready (ready),
        .o_done     (b_done)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a read at the current negedge, then follow the frame byte by byte.
    // Returns at the negedge of the o_done cycle.
    task automatic read_frame(input bit sel, input logic [7:0] a, input logic [39:0] exp,
                              input bit bp, input bit disturb);
        int          b = 0;
        int          cyc = 0;
        logic [39:0] f;
        f    = exp;
        rd   = 1'b1;
        addr = a;
        @(posedge clk);
        #1 rd = 1'b0;
        while (b < 5 && cyc < 60) begin
            @(negedge clk);
            check($sformatf("valid a%0h b%0d", a, b), sel ? b_valid : a_valid, 40'd1);
            check($sformatf("busy a%0h b%0d", a, b), sel ? b_busy : a_busy, 40'd1);
            check($sformatf("data a%0h b%0d", a, b), sel ? b_data : a_data, {32'd0, f[8*b +: 8]});
            ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (disturb && cyc == 1) begin
                rd          = 1'b1;
                addr        = 8'h02;
                regs[63:32] = 32'h9999_9999;
            end
            if (ready) b++;
            cyc++;
        end
        check($sformatf("frame length a%0h", a), 40'(b), 40'd5);
        @(negedge clk);
        check($sformatf("done a%0h", a), sel ? b_done : a_done, 40'd1);
        check($sformatf("busy end a%0h", a), sel ? b_busy : a_busy, 40'd0);
        check($sformatf("valid end a%0h", a), sel ? b_valid : a_valid, 40'd0);
        check($sformatf("data end a%0h", a), sel ? b_data : a_data, 40'd0);
        rd    = 1'b0;
        ready = 1'b1;
    endtask

    task automatic idle_check(input bit sel, input string tag);
        @(negedge clk);
        check({tag, " done"}, sel ? b_done : a_done, 40'd0);
        check({tag, " busy"}, sel ? b_busy : a_busy, 40'd0);
        check({tag, " valid"}, sel ? b_valid : a_valid, 40'd0);
        check({tag, " data"}, sel ? b_data : a_data, 40'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        rd    = 1'b0;
        addr  = 8'h00;
        ready = 1'b1;
        regs  = '0;
        regs[31:0]    = 32'hCAFE_BABE;
        regs[63:32]   = 32'h1122_3344;
        regs[127:96]  = 32'hA1B2_C3D4;
        regs[191:160] = 32'h5566_7788;
        regs[255:224] = 32'hDEAD_BEEF;
        #1 rst_n = 1'b0;
        #2;
        check("reset valid", a_valid, 40'd0);
        check("reset busy", a_busy, 40'd0);
        check("reset done", a_done, 40'd0);
        check("reset data", a_data, 40'd0);
        check("reset valid b", b_valid, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic read, full throughput
        read_frame(1'b0, 8'd3, {32'hA1B2_C3D4, 8'h03}, 1'b0, 1'b0);
        idle_check(1'b0, "after basic");

        // Backpressure
        read_frame(1'b0, 8'd3, {32'hA1B2_C3D4, 8'h03}, 1'b1, 1'b0);
        idle_check(1'b0, "after bp");

        // Out of range
        read_frame(1'b0, 8'd8, {32'h0, 8'hFF}, 1'b0, 1'b0);
        idle_check(1'b0, "after oor8");
        read_frame(1'b0, 8'd200, {32'h0, 8'hFF}, 1'b0, 1'b0);
        idle_check(1'b0, "after oor200");

        // Request dropped while busy, snapshot held, then read in the o_done cycle
        read_frame(1'b0, 8'd1, {32'h1122_3344, 8'h01}, 1'b0, 1'b1);
        read_frame(1'b0, 8'd1, {32'h9999_9999, 8'h01}, 1'b0, 1'b0);
        idle_check(1'b0, "after chain");

        // Reset in the middle of a frame
        rd   = 1'b1;
        addr = 8'd5;
        @(posedge clk);
        #1 rd = 1'b0;
        @(negedge clk);
        check("mid byte0", a_data, 40'h05);
        @(negedge clk);
        check("mid byte1", a_data, 40'h88);
        @(negedge clk);
        check("mid byte2", a_data, 40'h77);
        #2 rst_n = 1'b0;
        #1;
        check("abort valid", a_valid, 40'd0);
        check("abort busy", a_busy, 40'd0);
        check("abort data", a_data, 40'd0);
        check("abort done", a_done, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_frame(1'b0, 8'd5, {32'h5566_7788, 8'h05}, 1'b0, 1'b0);
        idle_check(1'b0, "after reset frame");

        // Base address 16
        read_frame(1'b1, 8'd15, {32'h0, 8'hFF}, 1'b0, 1'b0);
        idle_check(1'b1, "b after 15");
        read_frame(1'b1, 8'd16, {32'hCAFE_BABE, 8'h10}, 1'b0, 1'b0);
        idle_check(1'b1, "b after 16");
        read_frame(1'b1, 8'd23, {32'hDEAD_BEEF, 8'h17}, 1'b0, 1'b0);
        idle_check(1'b1, "b after 23");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
